// File: rtl/tx_store_forward.sv
// tx_store_forward
// Store-and-forward frame buffer on the 64-bit AXI4-Stream transmit path.
// A frame is only made visible to the MAC side once its last beat has been
// written. The MAC therefore receives every frame as one unbroken burst and
// can never underrun mid-frame. Frames longer than MAX_WORDS are discarded
// whole and counted.
//
// Optional feature macro: TX_SF_STATS_EN
//   defined   -> frame_count / drop_count saturating statistics registers
//   undefined -> both statistics outputs tied to zero
module tx_store_forward #(
  parameter int DEPTH     = 512,
  parameter int MAX_WORDS = 192
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic [63:0] axi_str_tdata_from_fifo,
  input  logic [7:0]  axi_str_tkeep_from_fifo,
  input  logic        axi_str_tvalid_from_fifo,
  input  logic        axi_str_tlast_from_fifo,
  output logic        axi_str_tready_to_fifo,
  output logic [63:0] axi_str_tdata_to_mac,
  output logic [7:0]  axi_str_tkeep_to_mac,
  output logic        axi_str_tvalid_to_mac,
  output logic        axi_str_tlast_to_mac,
  input  logic        axi_str_tready_from_mac,
  output logic [31:0] frame_count,
  output logic [31:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);
  localparam logic [CW-1:0] WORD_LIMIT = CW'(MAX_WORDS);

  // A buffer no deeper than the largest frame could fill up with a single
  // uncommitted frame and never drain, so refuse to elaborate that case.
  if (DEPTH <= MAX_WORDS) begin : g_depthTooSmall
    $error("tx_store_forward: DEPTH must be greater than MAX_WORDS");
  end
  if ((1 << AW) != DEPTH) begin : g_depthNotPow2
    $error("tx_store_forward: DEPTH must be a power of two");
  end

  typedef enum logic {
    ST_ACCEPT,
    ST_DROP
  } wr_state_t;

  // Storage word layout: {tlast, tkeep[7:0], tdata[63:0]}
  logic [72:0]   r_mem [DEPTH];

  // Write side. r_wrPtr is the next free word, r_commitPtr marks the end of
  // the last complete frame; everything between them is a frame in progress.
  wr_state_t     r_wState;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_commitPtr;
  logic [CW-1:0] r_wCnt;

  // Read side. r_fetchPtr runs ahead of r_rdPtr by the words sitting in the
  // RAM output register and the output register; r_rdPtr only moves when
  // the MAC actually takes a beat, so those words still count as used.
  logic [PW-1:0] r_fetchPtr;
  logic [PW-1:0] r_rdPtr;
  logic [72:0]   r_ramQ;
  logic          r_ramQValid;
  logic [72:0]   r_outWord;
  logic          r_outValid;

  logic [PW-1:0] w_used;
  logic          w_full;
  logic          w_inReady;
  logic          w_inHs;
  logic          w_overLimit;
  logic          w_writeEn;
  logic          w_outHs;
  logic          w_outLoad;
  logic          w_fetch;

  // Occupancy is taken from registered pointers only, so a beat leaving on
  // the MAC side frees space for the writer one cycle later.
  assign w_used      = r_wrPtr - r_rdPtr;
  assign w_full      = (w_used == FULL_LEVEL);

  // While discarding an oversized frame the writer swallows beats even when
  // full; holding reset low-ready keeps the upstream slice from pushing data
  // that would be thrown away anyway.
  assign w_inReady   = !reset && ((r_wState == ST_DROP) || !w_full);
  assign w_inHs      = axi_str_tvalid_from_fifo && w_inReady;

  // r_wCnt holds the number of words already stored for the current frame,
  // so reaching the limit means this beat would be one word too many.
  assign w_overLimit = (r_wCnt == WORD_LIMIT);
  assign w_writeEn   = w_inHs && (r_wState == ST_ACCEPT) && !w_overLimit;

  assign w_outHs     = r_outValid && axi_str_tready_from_mac;
  assign w_outLoad   = !r_outValid || axi_str_tready_from_mac;

  // A new RAM read may be started when committed data is waiting and the
  // RAM output register is either empty or being moved on this cycle.
  assign w_fetch     = (r_fetchPtr != r_commitPtr) && (!r_ramQValid || w_outLoad);

  // Write FSM: stores beats, commits complete frames, and rewinds plus
  // switches to discarding as soon as a frame grows past the size limit.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_wState    <= ST_ACCEPT;
      r_wrPtr     <= '0;
      r_commitPtr <= '0;
      r_wCnt      <= '0;
    end else if (w_inHs) begin
      case (r_wState)
        ST_ACCEPT: begin
          if (w_overLimit) begin
            r_wrPtr <= r_commitPtr;
            r_wCnt  <= '0;
            if (!axi_str_tlast_from_fifo) begin
              r_wState <= ST_DROP;
            end
          end else begin
            r_wrPtr <= r_wrPtr + PW'(1);
            if (axi_str_tlast_from_fifo) begin
              r_commitPtr <= r_wrPtr + PW'(1);
              r_wCnt      <= '0;
            end else begin
              r_wCnt <= r_wCnt + CW'(1);
            end
          end
        end
        ST_DROP: begin
          if (axi_str_tlast_from_fifo) begin
            r_wState <= ST_ACCEPT;
            r_wCnt   <= '0;
          end
        end
        default: begin
          r_wState <= ST_ACCEPT;
        end
      endcase
    end
  end

  // Frame storage write port; kept free of reset so it maps onto block RAM.
  always_ff @(posedge user_clk) begin
    if (w_writeEn) begin
      r_mem[r_wrPtr[AW-1:0]] <= {axi_str_tlast_from_fifo,
                                 axi_str_tkeep_from_fifo,
                                 axi_str_tdata_from_fifo};
    end
  end

  // Registered RAM read port feeding the prefetch stage.
  always_ff @(posedge user_clk) begin
    if (w_fetch) begin
      r_ramQ <= r_mem[r_fetchPtr[AW-1:0]];
    end
  end

  // Fetch pointer and validity of the RAM output register. The register is
  // refilled in the same cycle it hands its word on, which is what keeps
  // committed frames streaming without bubbles.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_fetchPtr  <= '0;
      r_ramQValid <= 1'b0;
    end else if (w_fetch) begin
      r_fetchPtr  <= r_fetchPtr + PW'(1);
      r_ramQValid <= 1'b1;
    end else if (w_outLoad) begin
      r_ramQValid <= 1'b0;
    end
  end

  // Output register toward the MAC; it only changes when empty or when the
  // current beat is accepted, so data is held steady under back-pressure.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outWord  <= '0;
    end else if (w_outLoad) begin
      r_outValid <= r_ramQValid;
      if (r_ramQValid) begin
        r_outWord <= r_ramQ;
      end
    end
  end

  // Read pointer advances once per beat the MAC accepts and is the pointer
  // the occupancy calculation uses to free space.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_rdPtr <= '0;
    end else if (w_outHs) begin
      r_rdPtr <= r_rdPtr + PW'(1);
    end
  end

  assign axi_str_tready_to_fifo = w_inReady;
  assign axi_str_tvalid_to_mac  = r_outValid;
  assign axi_str_tlast_to_mac   = r_outWord[72];
  assign axi_str_tkeep_to_mac   = r_outWord[71:64];
  assign axi_str_tdata_to_mac   = r_outWord[63:0];

`ifdef TX_SF_STATS_EN
  logic [31:0] r_frameCount;
  logic [31:0] r_dropCount;
  logic        w_dropStart;

  assign w_dropStart = w_inHs && (r_wState == ST_ACCEPT) && w_overLimit;

  // Saturating statistics: frames completely handed to the MAC and frames
  // thrown away for exceeding the size limit.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_frameCount <= '0;
      r_dropCount  <= '0;
    end else begin
      if (w_outHs && r_outWord[72] && (r_frameCount != '1)) begin
        r_frameCount <= r_frameCount + 32'd1;
      end
      if (w_dropStart && (r_dropCount != '1)) begin
        r_dropCount <= r_dropCount + 32'd1;
      end
    end
  end

  assign frame_count = r_frameCount;
  assign drop_count  = r_dropCount;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule
